// File: rtl/round_key_scheduler.sv
// ============================================================================
// Module   : round_key_scheduler
// Brief    : AES key expansion (nk = 4/6/8) producing one schedule word per
//            cycle, with registered round-key read port. Optional macro
//            KS_DEC_ORDER_EN adds a 'dec' input for reverse-order reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module round_key_scheduler #(
  parameter int nk = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [32*nk-1:0]  key_in,
  output logic              busy,
  output logic              done,
  input  logic [3:0]        rk_idx,
`ifdef KS_DEC_ORDER_EN
  input  logic              dec,
`endif
  output logic [127:0]      rk_data
);

  localparam int         c_NR       = nk + 6;
  localparam int         c_NW       = 4 * (c_NR + 1);
  localparam logic [5:0] c_LAST     = 6'(c_NW - 1);
  localparam logic [3:0] c_NR4      = 4'(c_NR);
  localparam logic [2:0] c_POS_LAST = 3'(nk - 1);

  // FIPS-197 S-box, entry 0 in the most significant byte
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] f_sbox(input logic [7:0] b);
    return c_SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        w_accept;
  logic [31:0] r_w   [0:c_NW-1];
  logic [31:0] r_win [0:nk-1];
  logic [5:0]  r_i;
  logic [2:0]  r_pos;
  logic [7:0]  r_rcon;
  logic [31:0] w_rot, w_sub_rot, w_sub_last, w_t, w_new;
  logic [3:0]  w_ridx;
  logic [5:0]  w_base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = EXPAND;
          w_accept    = 1'b1;
        end
      end
      EXPAND:  if (r_i == c_LAST) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy = (r_state == EXPAND);
  assign done = (r_state == DONE);

  // r_win[nk-1] holds w[i-1], r_win[0] holds w[i-nk]
  assign w_rot = {r_win[nk-1][23:0], r_win[nk-1][31:24]};

  generate
    for (genvar b = 0; b < 4; b++) begin : g_sbox
      assign w_sub_rot[8*b +: 8]  = f_sbox(w_rot[8*b +: 8]);
      assign w_sub_last[8*b +: 8] = f_sbox(r_win[nk-1][8*b +: 8]);
    end
  endgenerate

  always_comb begin
    w_t = r_win[nk-1];
    if (r_pos == 3'd0)
      w_t = w_sub_rot ^ {r_rcon, 24'h0};
    else if (nk == 8 && r_pos == 3'd4)
      w_t = w_sub_last;
    w_new = r_win[0] ^ w_t;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i    <= 6'd0;
      r_pos  <= 3'd0;
      r_rcon <= 8'h01;
      for (int j = 0; j < nk; j++) r_win[j] <= 32'h0;
    end else if (w_accept) begin
      r_i    <= 6'(nk);
      r_pos  <= 3'd0;
      r_rcon <= 8'h01;
      for (int j = 0; j < nk; j++) r_win[j] <= key_in[32*(nk-j)-1 -: 32];
    end else if (busy) begin
      for (int j = 0; j < nk - 1; j++) r_win[j] <= r_win[j+1];
      r_win[nk-1] <= w_new;
      r_i         <= r_i + 6'd1;
      r_pos       <= (r_pos == c_POS_LAST) ? 3'd0 : r_pos + 3'd1;
      if (r_pos == 3'd0)
        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end
  end

  // Word storage is never reset; reads are gated by the DONE state instead
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int j = 0; j < nk; j++) r_w[j] <= key_in[32*(nk-j)-1 -: 32];
    end else if (busy) begin
      r_w[r_i] <= w_new;
    end
  end

`ifdef KS_DEC_ORDER_EN
  assign w_ridx = dec ? (c_NR4 - rk_idx) : rk_idx;
`else
  assign w_ridx = rk_idx;
`endif
  assign w_base = {w_ridx, 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rk_data <= 128'h0;
    else if (r_state == DONE && rk_idx <= c_NR4)
      rk_data <= {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
    else
      rk_data <= 128'h0;
  end

endmodule

`default_nettype wire

// File: tb/tb_round_key_scheduler.sv
// ============================================================================
// Module   : tb_round_key_scheduler
// Brief    : Bench for round_key_scheduler, nk = 4/6/8 instances side by side,
//            checked against an arithmetic AES key-expansion model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_round_key_scheduler;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key4 = '0;
  logic [191:0] key6 = '0;
  logic [255:0] key8 = '0;
  logic [3:0]   rk_idx = 4'd0;
  logic         busy4, busy6, busy8, done4, done6, done8;
  logic [127:0] rk4, rk6, rk8;
`ifdef KS_DEC_ORDER_EN
  logic         dec = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [255:0] cur4, cur6, cur8;
  int  lat4, lat6, lat8, bc4, bc6, bc8;
  bit  both_high, rd_busy_bad;
  logic [7:0] sbox [0:255];

  always #5 clk = ~clk;

  round_key_scheduler #(.nk(4)) u_ks4 (
    .clk(clk), .reset(reset), .start(start), .key_in(key4), .busy(busy4), .done(done4),
`ifdef KS_DEC_ORDER_EN
    .rk_idx(rk_idx), .dec(dec), .rk_data(rk4));
`else
    .rk_idx(rk_idx), .rk_data(rk4));
`endif
  round_key_scheduler #(.nk(6)) u_ks6 (
    .clk(clk), .reset(reset), .start(start), .key_in(key6), .busy(busy6), .done(done6),
`ifdef KS_DEC_ORDER_EN
    .rk_idx(rk_idx), .dec(dec), .rk_data(rk6));
`else
    .rk_idx(rk_idx), .rk_data(rk6));
`endif
  round_key_scheduler #(.nk(8)) u_ks8 (
    .clk(clk), .reset(reset), .start(start), .key_in(key8), .busy(busy8), .done(done8),
`ifdef KS_DEC_ORDER_EN
    .rk_idx(rk_idx), .dec(dec), .rk_data(rk8));
`else
    .rk_idx(rk_idx), .rk_data(rk8));
`endif

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    logic [7:0] y = x;
    for (int n = 0; n < k; n++) y = {y[6:0], y[7]};
    return y;
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // Round key r of the schedule for an n-word key (key right-justified)
  function automatic logic [127:0] model_rk(input int n, input logic [255:0] key, input int r);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < n; i++) w[i] = key[32*(n-i)-1 -: 32];
    for (int i = n; i < 4 * (n + 7); i++) begin
      t = w[i-1];
      if (i % n == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (n == 8 && i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-n] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] exp_rk(input int n, input logic [255:0] key, input int r);
    return (r <= n + 6) ? model_rk(n, key, r) : 128'h0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic load_keys(input logic [255:0] k4, input logic [255:0] k6, input logic [255:0] k8);
    cur4 = k4; cur6 = k6; cur8 = k8;
    key4 = k4[127:0]; key6 = k6[191:0]; key8 = k8;
  endtask

  // Pulse start, then watch 60 cycles; optional second start (with altered keys) at cycle inj
  task automatic run_expand(input int inj);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat4 = -1; lat6 = -1; lat8 = -1;
    bc4 = busy4 ? 1 : 0; bc6 = busy6 ? 1 : 0; bc8 = busy8 ? 1 : 0;
    both_high = 1'b0; rd_busy_bad = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (inj != 0 && c == inj) begin
        start = 1'b1; key4 = ~key4; key6 = ~key6; key8 = ~key8;
      end
      if (inj != 0 && c == inj + 1) start = 1'b0;
      @(negedge clk);
      if (done4 && lat4 < 0) lat4 = c;
      if (done6 && lat6 < 0) lat6 = c;
      if (done8 && lat8 < 0) lat8 = c;
      if (busy4) bc4++;
      if (busy6) bc6++;
      if (busy8) bc8++;
      if ((busy4 && done4) || (busy6 && done6) || (busy8 && done8)) both_high = 1'b1;
      if ((busy4 && rk4 !== 128'h0) || (busy6 && rk6 !== 128'h0) || (busy8 && rk8 !== 128'h0))
        rd_busy_bad = 1'b1;
    end
    start = 1'b0;
    key4 = cur4[127:0]; key6 = cur6[191:0]; key8 = cur8;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy4, done4, busy6, done6, busy8, done8} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 000000", {busy4, done4, busy6, done6, busy8, done8});
    end
    tests++;
    if ((rk4 | rk6 | rk8) !== 128'h0) begin
      fails++; $display("FAIL reset_rk: got %h want 0", rk4 | rk6 | rk8);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_schedule(input string tag);
    for (int r = 0; r < 16; r++) begin
      rk_idx = 4'(r);
      @(negedge clk);
      tests++;
      if (rk4 !== exp_rk(4, cur4, r)) begin
        fails++; $display("FAIL %s rk4[%0d]: got %h want %h", tag, r, rk4, exp_rk(4, cur4, r));
      end
      tests++;
      if (rk6 !== exp_rk(6, cur6, r)) begin
        fails++; $display("FAIL %s rk6[%0d]: got %h want %h", tag, r, rk6, exp_rk(6, cur6, r));
      end
      tests++;
      if (rk8 !== exp_rk(8, cur8, r)) begin
        fails++; $display("FAIL %s rk8[%0d]: got %h want %h", tag, r, rk8, exp_rk(8, cur8, r));
      end
    end
  endtask

  task automatic test_latency(input string tag);
    tests++;
    if (lat4 != 40 || lat6 != 46 || lat8 != 52) begin
      fails++; $display("FAIL %s latency: got %0d/%0d/%0d want 40/46/52", tag, lat4, lat6, lat8);
    end
    tests++;
    if (bc4 != 40 || bc6 != 46 || bc8 != 52) begin
      fails++; $display("FAIL %s busy_cycles: got %0d/%0d/%0d want 40/46/52", tag, bc4, bc6, bc8);
    end
    tests++;
    if (both_high || rd_busy_bad) begin
      fails++; $display("FAIL %s busy_done_excl/read_busy: got %b%b want 00", tag, both_high, rd_busy_bad);
    end
  endtask

  task automatic test_vectors();
    load_keys(256'h2b7e151628aed2a6abf7158809cf4f3c,
              256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
              256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run_expand(0);
    test_latency("vectors");
    rk_idx = 4'd10; @(negedge clk);
    tests++;
    if (rk4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      fails++; $display("FAIL vec4_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk4);
    end
    rk_idx = 4'd0; @(negedge clk);
    tests++;
    if (rk4 !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      fails++; $display("FAIL vec4_rk0: got %h want 2b7e151628aed2a6abf7158809cf4f3c", rk4);
    end
    rk_idx = 4'd12; @(negedge clk);
    tests++;
    if (rk6[31:0] !== 32'h01002202) begin
      fails++; $display("FAIL vec6_rk12w3: got %h want 01002202", rk6[31:0]);
    end
    rk_idx = 4'd14; @(negedge clk);
    tests++;
    if (rk8[31:0] !== 32'h706c631e) begin
      fails++; $display("FAIL vec8_rk14w3: got %h want 706c631e", rk8[31:0]);
    end
    test_read_schedule("vectors");
  endtask

  task automatic test_random();
    for (int n = 0; n < 3; n++) begin
      load_keys({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      cur4[255:128] = '0; cur6[255:192] = '0;
      run_expand(0);
      test_latency("random");
      test_read_schedule("random");
    end
  endtask

  task automatic test_back_to_back();
    // Start accepted while DONE: done drops on the accepting edge
    load_keys({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    run_expand(0);
    test_latency("b2b");
    test_read_schedule("b2b");
  endtask

  task automatic test_reset_mid();
    load_keys(256'h2b7e151628aed2a6abf7158809cf4f3c, cur6, cur8);
    rk_idx = 4'd3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({busy4, done4, busy6, done6, busy8, done8} !== 6'b0 || (rk4 | rk6 | rk8) !== 128'h0) begin
      fails++; $display("FAIL reset_mid: got flags %b rk %h want 0", {busy4, done4, busy6, done6, busy8, done8}, rk4 | rk6 | rk8);
    end
    @(negedge clk); reset = 1'b0;
    run_expand(0);
    test_latency("after_reset");
    rk_idx = 4'd10; @(negedge clk);
    tests++;
    if (rk4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      fails++; $display("FAIL after_reset_rk10: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk4);
    end
    // Reset while DONE with a live read must clear rk_data without waiting for a clock
    #2 reset = 1'b1;
    #1;
    tests++;
    if (rk4 !== 128'h0 || done4 !== 1'b0) begin
      fails++; $display("FAIL reset_done: got rk %h done %b want 0 0", rk4, done4);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_start_during_expand();
    load_keys({$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    rk_idx = 4'd1;
    run_expand(10);
    test_latency("start_in_expand");
    rk_idx = 4'd15; @(negedge clk);
    tests++;
    if ((rk4 | rk6 | rk8) !== 128'h0) begin
      fails++; $display("FAIL idx15: got %h want 0", rk4 | rk6 | rk8);
    end
    test_read_schedule("start_in_expand");
  endtask

`ifdef KS_DEC_ORDER_EN
  task automatic test_dec();
    load_keys(256'h2b7e151628aed2a6abf7158809cf4f3c, cur6, cur8);
    run_expand(0);
    dec = 1'b1;
    for (int r = 0; r < 16; r++) begin
      rk_idx = 4'(r);
      @(negedge clk);
      tests++;
      if (rk4 !== ((r <= 10) ? model_rk(4, cur4, 10 - r) : 128'h0)) begin
        fails++; $display("FAIL dec rk4[%0d]: got %h", r, rk4);
      end
    end
    rk_idx = 4'd0; @(negedge clk);
    tests++;
    if (rk4 !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      fails++; $display("FAIL dec_rk0: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", rk4);
    end
    dec = 1'b0;
  endtask
`endif

  initial begin
    build_sbox();
    cur4 = '0; cur6 = '0; cur8 = '0;
    test_reset();
    test_vectors();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_start_during_expand();
`ifdef KS_DEC_ORDER_EN
    test_dec();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
